// File: rtl/cache_port_arbiter_if.sv
// Request, response and cache-side signals shared between the
// two requesters, the arbiter and the L1 cache port.
interface cache_port_arbiter_if #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 8
);
    logic               req0_valid;
    logic               req0_mode;
    logic [INDEX_W-1:0] req0_index;
    logic [TAG_W-1:0]   req0_tag;
    logic [DATA_W-1:0]  req0_data;
    logic               req0_ready;

    logic               req1_valid;
    logic               req1_mode;
    logic [INDEX_W-1:0] req1_index;
    logic [TAG_W-1:0]   req1_tag;
    logic [DATA_W-1:0]  req1_data;
    logic               req1_ready;

    logic               rsp0_valid;
    logic               rsp1_valid;
    logic [DATA_W-1:0]  rsp_data;

    logic               cache_mode;
    logic [INDEX_W-1:0] cache_index;
    logic [TAG_W-1:0]   cache_tag;
    logic [DATA_W-1:0]  cache_data;
    logic [DATA_W-1:0]  cache_data_out;

    modport slave (
        input  req0_valid, req0_mode, req0_index, req0_tag, req0_data,
        input  req1_valid, req1_mode, req1_index, req1_tag, req1_data,
        input  cache_data_out,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data,
        output cache_mode, cache_index, cache_tag, cache_data
    );

    modport master (
        output req0_valid, req0_mode, req0_index, req0_tag, req0_data,
        output req1_valid, req1_mode, req1_index, req1_tag, req1_data,
        output cache_data_out,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data,
        input  cache_mode, cache_index, cache_tag, cache_data
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one L1 cache port between two requesters;
// holds each granted request for HOLD_CYCLES, then returns the read data.
module cache_port_arbiter #(
    parameter int INDEX_W     = 2,
    parameter int TAG_W       = 8,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input logic                clock,
    input logic                reset,
    cache_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RESP
    } state_t;

    state_t             state_q;
    logic               last_q;
    logic               sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               mode_q;
    logic [INDEX_W-1:0] index_q;
    logic [TAG_W-1:0]   tag_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp0_q;
    logic               rsp1_q;

    logic               grant0;
    logic               grant1;
    logic               mode_d;
    logic [INDEX_W-1:0] index_d;
    logic [TAG_W-1:0]   tag_d;
    logic [DATA_W-1:0]  data_d;

    // last_q==1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
        grant1 = bus.req1_valid & ~grant0;
    end

    always_comb begin
        mode_d  = grant1 ? bus.req1_mode  : bus.req0_mode;
        index_d = grant1 ? bus.req1_index : bus.req0_index;
        tag_d   = grant1 ? bus.req1_tag   : bus.req0_tag;
        data_d  = grant1 ? bus.req1_data  : bus.req0_data;
    end

    assign bus.req0_ready  = (state_q == IDLE) & ~reset & grant0;
    assign bus.req1_ready  = (state_q == IDLE) & ~reset & grant1;
    assign bus.rsp0_valid  = rsp0_q;
    assign bus.rsp1_valid  = rsp1_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.cache_mode  = mode_q;
    assign bus.cache_index = index_q;
    assign bus.cache_tag   = tag_q;
    assign bus.cache_data  = data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            index_q    <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
        end else begin
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    mode_q <= 1'b0;
                    if (grant0 | grant1) begin
                        mode_q  <= mode_d;
                        index_q <= index_d;
                        tag_q   <= tag_d;
                        data_q  <= data_d;
                        sel_q   <= grant1;
                        last_q  <= grant1;
                        cnt_q   <= CNT_INIT;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_data_q <= bus.cache_data_out;
                        rsp0_q     <= ~sel_q;
                        rsp1_q     <= sel_q;
                        state_q    <= RESP;
                    end
                end
                RESP: begin
                    mode_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench: reference model predicts grants, hold window and
// response data; a monitor pops expected responses on each rsp pulse.
module tb_cache_port_arbiter;
    localparam int IW = 2;
    localparam int TW = 8;
    localparam int DW = 8;
    localparam int H  = 4;
    localparam int KW = IW + TW;

    typedef struct packed {
        logic          mode;
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } req_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) bus ();
    cache_port_arbiter_if #(.INDEX_W(IW), .TAG_W(TW), .DATA_W(DW)) bus1 ();

    cache_port_arbiter #(
        .INDEX_W(IW), .TAG_W(TW), .DATA_W(DW), .HOLD_CYCLES(H)
    ) dut (
        .clock(clk), .reset(rst), .bus(bus)
    );

    cache_port_arbiter #(
        .INDEX_W(IW), .TAG_W(TW), .DATA_W(DW), .HOLD_CYCLES(1)
    ) dut1 (
        .clock(clk), .reset(rst), .bus(bus1)
    );

    // behavioural cache stand-ins: write on each edge with mode=1
    logic [DW-1:0] mem  [0:(1<<KW)-1] = '{default: '0};
    logic [DW-1:0] mem1 [0:(1<<KW)-1] = '{default: '0};
    always @(posedge clk) if (bus.cache_mode)
        mem[{bus.cache_index, bus.cache_tag}] <= bus.cache_data;
    always @(posedge clk) if (bus1.cache_mode)
        mem1[{bus1.cache_index, bus1.cache_tag}] <= bus1.cache_data;
    assign bus.cache_data_out  = mem[{bus.cache_index, bus.cache_tag}];
    assign bus1.cache_data_out = mem1[{bus1.cache_index, bus1.cache_tag}];

    int total = 0;
    int bad   = 0;
    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // reference state
    logic [DW-1:0] ref_mem [logic [KW-1:0]];
    exp_t expq[$];
    int   m_busy = 0;
    bit   m_last = 1'b1;
    req_t m_req;
    logic [DW-1:0] m_pend = '0;
    logic [DW-1:0] m_rsp  = '0;
    bit   m_port = 1'b0;
    bit   post_rst = 1'b0;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;

    // driver state
    req_t dq0[$];
    req_t dq1[$];
    req_t cur0, cur1;
    bit   v0 = 1'b0;
    bit   v1 = 1'b0;
    int   rnd_pct = 0;

    function automatic logic [DW-1:0] rd(input logic [KW-1:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : '0;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.mode = 1'($urandom_range(0, 1));
        r.idx  = IW'($urandom_range(0, 3));
        r.tag  = TW'($urandom_range(0, 3));
        r.data = DW'($urandom);
        return r;
    endfunction

    // model: arbitration by rule, then a busy window of H hold + 1 resp
    always @(negedge clk) begin : model
        bit   any;
        bit   win;
        req_t r;
        exp_t e;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            chk("ready0_in_reset", bus.req0_ready, 0);
            chk("ready1_in_reset", bus.req1_ready, 0);
            m_busy = 0;
            m_last = 1'b1;
            m_rsp = '0;
            expq.delete();
            post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("reset_cache_fields",
                    {bus.cache_mode, bus.cache_index, bus.cache_tag,
                     bus.cache_data}, 0);
                chk("reset_rsp",
                    {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data}, 0);
                post_rst = 1'b0;
            end
            if (m_busy == 0) begin
                any = v0 | v1;
                if (v0 && v1) win = ~m_last;
                else          win = v1;
                chk("ready0", bus.req0_ready, any && !win);
                chk("ready1", bus.req1_ready, any && win);
                chk("idle_mode", bus.cache_mode, 0);
                if (any) begin
                    r = win ? cur1 : cur0;
                    m_pend = r.mode ? r.data : rd({r.idx, r.tag});
                    if (r.mode) ref_mem[{r.idx, r.tag}] = r.data;
                    e.port = win;
                    e.data = m_pend;
                    e.cyc  = cyc + H + 1;
                    expq.push_back(e);
                    m_last = win;
                    m_port = win;
                    m_req  = r;
                    m_busy = H + 1;
                    if (win) acc1 = 1'b1;
                    else     acc0 = 1'b1;
                end
            end else begin
                chk("ready_busy", {bus.req0_ready, bus.req1_ready}, 0);
                if (m_busy > 1) begin
                    chk("hold_fields",
                        {bus.cache_mode, bus.cache_index, bus.cache_tag,
                         bus.cache_data}, m_req);
                end else begin
                    m_rsp = m_pend;
                    chk("rsp_pulse", {bus.rsp1_valid, bus.rsp0_valid},
                        m_port ? 2 : 1);
                end
                m_busy--;
            end
            chk("rsp_data_hold", bus.rsp_data, m_rsp);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.rsp0_valid || bus.rsp1_valid)) begin
            chk("rsp_one_hot", bus.rsp0_valid & bus.rsp1_valid, 0);
            if (expq.size() == 0) begin
                chk("rsp_unexpected", {bus.rsp1_valid, bus.rsp0_valid}, 0);
            end else begin
                e = expq.pop_front();
                chk("rsp_port", bus.rsp1_valid, e.port);
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_data", bus.rsp_data, e.data);
            end
        end
    end

    task automatic drive();
        bus.req0_valid = v0;
        bus.req0_mode  = cur0.mode;
        bus.req0_index = cur0.idx;
        bus.req0_tag   = cur0.tag;
        bus.req0_data  = cur0.data;
        bus.req1_valid = v1;
        bus.req1_mode  = cur1.mode;
        bus.req1_index = cur1.idx;
        bus.req1_tag   = cur1.tag;
        bus.req1_data  = cur1.data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (v0 && acc0) v0 = 1'b0;
        if (v1 && acc1) v1 = 1'b0;
        if (!v0) begin
            if (dq0.size() != 0) begin
                cur0 = dq0.pop_front();
                v0 = 1'b1;
            end else if (rnd_pct != 0 && $urandom_range(0, 99) < rnd_pct) begin
                cur0 = rand_req();
                v0 = 1'b1;
            end
        end
        if (!v1) begin
            if (dq1.size() != 0) begin
                cur1 = dq1.pop_front();
                v1 = 1'b1;
            end else if (rnd_pct != 0 && $urandom_range(0, 99) < rnd_pct) begin
                cur1 = rand_req();
                v1 = 1'b1;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((v0 || v1 || dq0.size() != 0 || dq1.size() != 0 ||
                m_busy != 0) && n < maxc) begin
            step();
            n++;
        end
        step();
        if (n >= maxc) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: waited %0d cycles", n);
        end
    endtask

    task automatic h1_req(input req_t r, input bit chk_data);
        bus1.req0_valid = 1'b1;
        bus1.req0_mode  = r.mode;
        bus1.req0_index = r.idx;
        bus1.req0_tag   = r.tag;
        bus1.req0_data  = r.data;
        @(negedge clk);
        chk("h1_ready", bus1.req0_ready, 1);
        @(posedge clk);
        #1 bus1.req0_valid = 1'b0;
        @(negedge clk);
        chk("h1_hold_fields",
            {bus1.cache_mode, bus1.cache_index, bus1.cache_tag,
             bus1.cache_data}, r);
        chk("h1_no_early_rsp", bus1.rsp0_valid, 0);
        @(negedge clk);
        chk("h1_rsp_pulse", {bus1.rsp1_valid, bus1.rsp0_valid}, 1);
        if (chk_data) chk("h1_rsp_data", bus1.rsp_data, 8'h3C);
        @(negedge clk);
        chk("h1_pulse_end", bus1.rsp0_valid, 0);
        chk("h1_idle_mode", bus1.cache_mode, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cur0 = '0;
        cur1 = '0;
        drive();
        bus1.req0_valid = 1'b0;
        bus1.req0_mode  = 1'b0;
        bus1.req0_index = '0;
        bus1.req0_tag   = '0;
        bus1.req0_data  = '0;
        bus1.req1_valid = 1'b0;
        bus1.req1_mode  = 1'b0;
        bus1.req1_index = '0;
        bus1.req1_tag   = '0;
        bus1.req1_data  = '0;
        do_reset();

        // single write from requester 0
        dq0.push_back('{1'b1, 2'd3, 8'h00, 8'h01});
        drain(50);

        // both requesters continuously valid: grants alternate
        for (int i = 0; i < 3; i++) begin
            dq0.push_back(rand_req());
            dq1.push_back(rand_req());
        end
        drain(100);

        // write then read back through the cache
        dq0.push_back('{1'b1, 2'd3, 8'h01, 8'h0A});
        dq0.push_back('{1'b0, 2'd3, 8'h01, 8'h00});
        drain(50);

        // only requester 1 after reset, then both
        do_reset();
        dq1.push_back(rand_req());
        dq1.push_back(rand_req());
        step();
        step();
        dq0.push_back(rand_req());
        drain(100);

        // reset two cycles into the hold window
        dq0.push_back('{1'b1, 2'd2, 8'h02, 8'h55});
        for (int n = 0; n < 20 && m_busy == 0; n++) step();
        dq1.push_back('{1'b0, 2'd2, 8'h02, 8'h00});
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drain(50);

        // randomized traffic
        rnd_pct = 40;
        repeat (400) step();
        rnd_pct = 0;
        drain(200);
        chk("scoreboard_empty", expq.size(), 0);

        // single-cycle hold build
        h1_req('{1'b1, 2'd2, 8'h05, 8'h3C}, 1'b0);
        h1_req('{1'b0, 2'd2, 8'h05, 8'h00}, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
